l2_set_buf: RTL and testbench
=============================

# l2_set_buf

Parametrised L2 set buffer, the next generation of the L2 read-set buffers. It sits between the L2 localmem and the L2 FSM. It issues a set read with a configurable read latency and captures all ways of the set (lines, tags, hprots, per-word states, evict way). It lets the FSM apply masked per-way, per-word updates with dirty tracking, and writes dirty ways back to localmem through a valid/ready flush sequencer.

## Interface
Parameters:
- WAYS, 8: ways per set, power of 2, at least 2
- WORDS, 2: words per line
- WORD_BITS, 64: word width
- TAG_BITS, 16: tag width
- HPROT_BITS, 1: hprot width
- STATE_BITS, 3: per-word state width
- SET_BITS, 9: set index width
- RD_LAT, 1: localmem read latency in cycles, 1..4

Ports (WB = $clog2(WAYS); all multi-way outputs are flat vectors with way i at slice i):
- clk in 1: clock
- rst in 1: reset. Asynchronous, active-low.
- load_req in 1: request to capture set load_set
- load_set in SET_BITS: set index to load
- load_ready out 1: load can be accepted
- lmem_rd_en out 1: read strobe to localmem
- lmem_rd_set out SET_BITS: set index for the read
- lmem_rd_data_evict_way in WB: evict way from localmem
- lmem_rd_data_line in WAYS*WORDS*WORD_BITS: line data from localmem
- lmem_rd_data_tag in WAYS*TAG_BITS: tags from localmem
- lmem_rd_data_hprot in WAYS*HPROT_BITS: hprots from localmem
- lmem_rd_data_state in WAYS*WORDS*STATE_BITS: per-word states from localmem
- buf_valid out 1: buffer holds a valid set
- buf_set out SET_BITS: set index held in the buffer
- dirty out WAYS: per-way dirty flags
- evict_way_buf out WB: buffered evict way
- lines_buf out WAYS*WORDS*WORD_BITS: buffered line data
- tags_buf out WAYS*TAG_BITS: buffered tags
- hprots_buf out WAYS*HPROT_BITS: buffered hprots
- states_buf out WAYS*WORDS*STATE_BITS: buffered per-word states
- upd_en in 1: apply an update
- upd_way in WB: way to update
- upd_word_en in WORDS: per-word write mask
- upd_line in WORDS*WORD_BITS: new word data
- upd_state in WORDS*STATE_BITS: new per-word states
- upd_tag_en in 1: also write tag and hprot
- upd_tag in TAG_BITS: new tag
- upd_hprot in HPROT_BITS: new hprot
- upd_ready out 1: update can be accepted
- flush_req in 1: request write-back of dirty ways
- lmem_wr_valid out 1: write-back beat valid
- lmem_wr_ready in 1: localmem accepts the beat
- lmem_wr_set out SET_BITS: set index of the beat
- lmem_wr_way out WB: way of the beat
- lmem_wr_line, lmem_wr_tag, lmem_wr_hprot, lmem_wr_state out: contents of way lmem_wr_way
- flush_done out 1: one-cycle pulse when a flush completes

## Operation
States: IDLE, WAIT, HOLD, FLUSH.
- Reset value of every output and register is 0; state is IDLE.
- load_ready is 1 in IDLE, and in HOLD when dirty == 0.
- upd_ready is 1 only in HOLD.

Loading:
- A load is accepted when load_req && load_ready && !flush_req.
- On accept: lmem_rd_en = 1 for that one cycle, lmem_rd_set = load_set, buf_set latches load_set, buf_valid clears, state goes to WAIT, and the latency counter loads RD_LAT-1.
- WAIT counts down. When the counter reaches 0, the cycle samples all lmem_rd_data_*, clears dirty and moves to HOLD (buf_valid = 1).
- load_req in WAIT, FLUSH, or HOLD with dirty != 0 is ignored. No queueing.

Updates (HOLD only):
- upd_en writes word w of way upd_way for every w with upd_word_en[w] = 1, covering both line data and state.
- If upd_tag_en = 1, the tag and hprot are written too.
- dirty[upd_way] is set if any mask bit is set or upd_tag_en = 1.
- upd_en outside HOLD has no effect.

Flushing:
- flush_req is accepted in any state except WAIT and FLUSH (it is ignored in WAIT).
- If dirty == 0, or the state is IDLE: flush_done pulses the next cycle and no beats are issued.
- Otherwise the state goes to FLUSH. Beats are issued for dirty ways in ascending way order.
- lmem_wr_* is stable while lmem_wr_valid && !lmem_wr_ready.
- On each handshake the beat's dirty bit clears and the next dirty way is presented the following cycle.
- After the last handshake: flush_done pulses in the next cycle, the state returns to HOLD, and the buffer contents are retained.

Simultaneous events:
- upd_en and flush_req in the same HOLD cycle: the update applies first, and the flush includes that way.
- load_req and flush_req in the same cycle: the flush wins.

## Timing
- Load accepted at cycle T: lmem_rd_en is high at T; data is sampled at the clock edge ending cycle T+RD_LAT; buf_valid is 1 from cycle T+RD_LAT+1.
- Update issued at cycle T is visible on the *_buf outputs and dirty at T+1.
- With lmem_wr_ready held at 1, N dirty ways take N cycles. The first beat is at T+1 after a flush accepted at T; flush_done is at T+N+1.
- rst low at any time, including mid-WAIT or mid-FLUSH, clears all outputs and state immediately (lmem_wr_valid drops asynchronously). The aborted flush produces no flush_done.

## Test plan
- RD_LAT=3: load set 0x1A3 at cycle 10 -> lmem_rd_en only at cycle 10; buf_valid rises at cycle 14; buffers equal the localmem data; dirty = 0.
- Update way 5 with upd_word_en = 2'b10, upd_state = 3 -> only word 1 of way 5 changes; dirty = 8'h20; load_req is then ignored (load_ready = 0).
- Dirty = 8'h91, flush with lmem_wr_ready stalled 2 cycles on the first beat -> beats for ways 0, 4, 7 in that order, data stable during the stall; flush_done 1 cycle after the way-7 handshake; dirty = 0.
- Flush in IDLE, and flush in HOLD with dirty = 0 -> flush_done the next cycle; lmem_wr_valid never asserted.
- upd_en on way 2 together with flush_req in the same cycle -> the way-2 beat carries the updated data; load_req in the same cycle as flush_req is ignored.
- Assert rst mid-flush after one of three beats -> all outputs 0 at once; state IDLE; no flush_done.

Source files
------------

// File: rtl/l2_set_buf.sv
// l2_set_buf: L2 set buffer between the L2 localmem and the L2 FSM.
//
// Purpose:
//   Reads one set from localmem with a read latency of RD_LAT cycles and
//   captures every way of it (lines, tags, hprots, per-word states, evict
//   way). While holding a set, the FSM applies masked per-way, per-word
//   updates, and each updated way is marked dirty. A flush writes the
//   dirty ways back in ascending way order over a valid/ready channel.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   load_req/load_set         capture request and set index; load_ready
//   lmem_rd_en/lmem_rd_set    read strobe and set index to localmem
//   lmem_rd_data_*            set contents returned by localmem
//   buf_valid/buf_set/dirty   buffer status
//   *_buf, evict_way_buf      buffered set contents (way i at slice i)
//   upd_*                     per-way masked update; upd_ready
//   flush_req                 write back the dirty ways
//   lmem_wr_*                 write-back beats (valid/ready)
//   flush_done                one-cycle pulse when a flush completes
module l2_set_buf #(
    parameter int WAYS       = 8,
    parameter int WORDS      = 2,
    parameter int WORD_BITS  = 64,
    parameter int TAG_BITS   = 16,
    parameter int HPROT_BITS = 1,
    parameter int STATE_BITS = 3,
    parameter int SET_BITS   = 9,
    parameter int RD_LAT     = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load_req,
    input  logic [SET_BITS-1:0]                 load_set,
    output logic                                load_ready,
    output logic                                lmem_rd_en,
    output logic [SET_BITS-1:0]                 lmem_rd_set,
    input  logic [$clog2(WAYS)-1:0]             lmem_rd_data_evict_way,
    input  logic [WAYS*WORDS*WORD_BITS-1:0]     lmem_rd_data_line,
    input  logic [WAYS*TAG_BITS-1:0]            lmem_rd_data_tag,
    input  logic [WAYS*HPROT_BITS-1:0]          lmem_rd_data_hprot,
    input  logic [WAYS*WORDS*STATE_BITS-1:0]    lmem_rd_data_state,
    output logic                                buf_valid,
    output logic [SET_BITS-1:0]                 buf_set,
    output logic [WAYS-1:0]                     dirty,
    output logic [$clog2(WAYS)-1:0]             evict_way_buf,
    output logic [WAYS*WORDS*WORD_BITS-1:0]     lines_buf,
    output logic [WAYS*TAG_BITS-1:0]            tags_buf,
    output logic [WAYS*HPROT_BITS-1:0]          hprots_buf,
    output logic [WAYS*WORDS*STATE_BITS-1:0]    states_buf,
    input  logic                                upd_en,
    input  logic [$clog2(WAYS)-1:0]             upd_way,
    input  logic [WORDS-1:0]                    upd_word_en,
    input  logic [WORDS*WORD_BITS-1:0]          upd_line,
    input  logic [WORDS*STATE_BITS-1:0]         upd_state,
    input  logic                                upd_tag_en,
    input  logic [TAG_BITS-1:0]                 upd_tag,
    input  logic [HPROT_BITS-1:0]               upd_hprot,
    output logic                                upd_ready,
    input  logic                                flush_req,
    output logic                                lmem_wr_valid,
    input  logic                                lmem_wr_ready,
    output logic [SET_BITS-1:0]                 lmem_wr_set,
    output logic [$clog2(WAYS)-1:0]             lmem_wr_way,
    output logic [WORDS*WORD_BITS-1:0]          lmem_wr_line,
    output logic [TAG_BITS-1:0]                 lmem_wr_tag,
    output logic [HPROT_BITS-1:0]               lmem_wr_hprot,
    output logic [WORDS*STATE_BITS-1:0]         lmem_wr_state,
    output logic                                flush_done
);

    localparam int WB     = $clog2(WAYS);
    localparam int LINE_W = WORDS * WORD_BITS;
    localparam int LST_W  = WORDS * STATE_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    state_e                          state_q, state_d;
    logic [1:0]                      cnt_q, cnt_d;
    logic                            buf_valid_q, buf_valid_d;
    logic [SET_BITS-1:0]             buf_set_q, buf_set_d;
    logic [WAYS-1:0]                 dirty_q, dirty_d;
    logic [WB-1:0]                   evict_q, evict_d;
    logic [WAYS*LINE_W-1:0]          lines_q, lines_d;
    logic [WAYS*TAG_BITS-1:0]        tags_q, tags_d;
    logic [WAYS*HPROT_BITS-1:0]      hprots_q, hprots_d;
    logic [WAYS*LST_W-1:0]           states_q, states_d;
    logic                            done_q, done_d;

    logic                            load_ok;
    logic                            flush_ok;
    logic [WB-1:0]                   wr_way;

    // Load is refused whenever a flush is requested in the same cycle.
    assign load_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && (dirty_q == '0));
    assign load_ok    = load_req && load_ready && !flush_req;
    assign flush_ok   = flush_req && ((state_q == S_IDLE) || (state_q == S_HOLD));
    assign upd_ready  = (state_q == S_HOLD);

    assign lmem_rd_en  = load_ok;
    assign lmem_rd_set = load_ok ? load_set : '0;

    // Lowest dirty way is the beat currently presented.
    always_comb begin
        wr_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (dirty_q[i]) wr_way = WB'(i);
        end
    end

    // A flush is only in progress while dirty ways remain, so valid
    // follows the state and the payload is held until the handshake.
    assign lmem_wr_valid = (state_q == S_FLUSH);
    assign lmem_wr_set   = lmem_wr_valid ? buf_set_q : '0;
    assign lmem_wr_way   = lmem_wr_valid ? wr_way : '0;
    assign lmem_wr_line  = lmem_wr_valid ? lines_q[int'(wr_way)*LINE_W +: LINE_W] : '0;
    assign lmem_wr_tag   = lmem_wr_valid ? tags_q[int'(wr_way)*TAG_BITS +: TAG_BITS] : '0;
    assign lmem_wr_hprot = lmem_wr_valid ? hprots_q[int'(wr_way)*HPROT_BITS +: HPROT_BITS] : '0;
    assign lmem_wr_state = lmem_wr_valid ? states_q[int'(wr_way)*LST_W +: LST_W] : '0;

    assign buf_valid     = buf_valid_q;
    assign buf_set       = buf_set_q;
    assign dirty         = dirty_q;
    assign evict_way_buf = evict_q;
    assign lines_buf     = lines_q;
    assign tags_buf      = tags_q;
    assign hprots_buf    = hprots_q;
    assign states_buf    = states_q;
    assign flush_done    = done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_valid_d = buf_valid_q;
        buf_set_d   = buf_set_q;
        dirty_d     = dirty_q;
        evict_d     = evict_q;
        lines_d     = lines_q;
        tags_d      = tags_q;
        hprots_d    = hprots_q;
        states_d    = states_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush_ok) begin
                    done_d = 1'b1;
                end else if (load_ok) begin
                    state_d     = S_WAIT;
                    cnt_d       = 2'(RD_LAT - 1);
                    buf_set_d   = load_set;
                    buf_valid_d = 1'b0;
                end
            end

            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d     = S_HOLD;
                    buf_valid_d = 1'b1;
                    dirty_d     = '0;
                    evict_d     = lmem_rd_data_evict_way;
                    lines_d     = lmem_rd_data_line;
                    tags_d      = lmem_rd_data_tag;
                    hprots_d    = lmem_rd_data_hprot;
                    states_d    = lmem_rd_data_state;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            S_HOLD: begin
                // The update lands before the flush decision so a
                // same-cycle flush sees the freshly dirtied way.
                if (upd_en) begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (upd_word_en[w]) begin
                            lines_d[(int'(upd_way)*WORDS + w)*WORD_BITS +: WORD_BITS] =
                                upd_line[w*WORD_BITS +: WORD_BITS];
                            states_d[(int'(upd_way)*WORDS + w)*STATE_BITS +: STATE_BITS] =
                                upd_state[w*STATE_BITS +: STATE_BITS];
                        end
                    end
                    if (upd_tag_en) begin
                        tags_d[int'(upd_way)*TAG_BITS +: TAG_BITS]       = upd_tag;
                        hprots_d[int'(upd_way)*HPROT_BITS +: HPROT_BITS] = upd_hprot;
                    end
                    if ((|upd_word_en) || upd_tag_en) begin
                        dirty_d[upd_way] = 1'b1;
                    end
                end

                if (flush_ok) begin
                    if (dirty_d == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else if (load_ok) begin
                    state_d     = S_WAIT;
                    cnt_d       = 2'(RD_LAT - 1);
                    buf_set_d   = load_set;
                    buf_valid_d = 1'b0;
                end
            end

            S_FLUSH: begin
                if (lmem_wr_ready) begin
                    dirty_d[wr_way] = 1'b0;
                    if (dirty_d == '0) begin
                        state_d = S_HOLD;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            buf_valid_q <= 1'b0;
            buf_set_q   <= '0;
            dirty_q     <= '0;
            evict_q     <= '0;
            lines_q     <= '0;
            tags_q      <= '0;
            hprots_q    <= '0;
            states_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_valid_q <= buf_valid_d;
            buf_set_q   <= buf_set_d;
            dirty_q     <= dirty_d;
            evict_q     <= evict_d;
            lines_q     <= lines_d;
            tags_q      <= tags_d;
            hprots_q    <= hprots_d;
            states_q    <= states_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_l2_set_buf.sv
// Directed bench for l2_set_buf with RD_LAT = 3 and default geometry.
module tb_l2_set_buf;

    localparam int WAYS = 8, WORDS = 2, WB = 3, WORD_BITS = 64, TAG_BITS = 16;
    localparam int HPROT_BITS = 1, STATE_BITS = 3, SET_BITS = 9, RD_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                             load_req = 1'b0;
    logic [SET_BITS-1:0]              load_set = '0;
    logic                             load_ready, lmem_rd_en;
    logic [SET_BITS-1:0]              lmem_rd_set;
    logic [WB-1:0]                    rd_evict;
    logic [WAYS*WORDS*WORD_BITS-1:0]  rd_line;
    logic [WAYS*TAG_BITS-1:0]         rd_tag;
    logic [WAYS*HPROT_BITS-1:0]       rd_hprot;
    logic [WAYS*WORDS*STATE_BITS-1:0] rd_state;
    logic                             buf_valid;
    logic [SET_BITS-1:0]              buf_set;
    logic [WAYS-1:0]                  dirty;
    logic [WB-1:0]                    evict_way_buf;
    logic [WAYS*WORDS*WORD_BITS-1:0]  lines_buf;
    logic [WAYS*TAG_BITS-1:0]         tags_buf;
    logic [WAYS*HPROT_BITS-1:0]       hprots_buf;
    logic [WAYS*WORDS*STATE_BITS-1:0] states_buf;
    logic                             upd_en = 1'b0;
    logic [WB-1:0]                    upd_way = '0;
    logic [WORDS-1:0]                 upd_word_en = '0;
    logic [WORDS*WORD_BITS-1:0]       upd_line = '0;
    logic [WORDS*STATE_BITS-1:0]      upd_state = '0;
    logic                             upd_tag_en = 1'b0;
    logic [TAG_BITS-1:0]              upd_tag = '0;
    logic [HPROT_BITS-1:0]            upd_hprot = '0;
    logic                             upd_ready;
    logic                             flush_req = 1'b0;
    logic                             lmem_wr_valid;
    logic                             lmem_wr_ready = 1'b0;
    logic [SET_BITS-1:0]              lmem_wr_set;
    logic [WB-1:0]                    lmem_wr_way;
    logic [WORDS*WORD_BITS-1:0]       lmem_wr_line;
    logic [TAG_BITS-1:0]              lmem_wr_tag;
    logic [HPROT_BITS-1:0]            lmem_wr_hprot;
    logic [WORDS*STATE_BITS-1:0]      lmem_wr_state;
    logic                             flush_done;

    l2_set_buf #(
        .WAYS(WAYS), .WORDS(WORDS), .WORD_BITS(WORD_BITS), .TAG_BITS(TAG_BITS),
        .HPROT_BITS(HPROT_BITS), .STATE_BITS(STATE_BITS), .SET_BITS(SET_BITS),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .load_req(load_req), .load_set(load_set), .load_ready(load_ready),
        .lmem_rd_en(lmem_rd_en), .lmem_rd_set(lmem_rd_set),
        .lmem_rd_data_evict_way(rd_evict), .lmem_rd_data_line(rd_line),
        .lmem_rd_data_tag(rd_tag), .lmem_rd_data_hprot(rd_hprot),
        .lmem_rd_data_state(rd_state),
        .buf_valid(buf_valid), .buf_set(buf_set), .dirty(dirty),
        .evict_way_buf(evict_way_buf), .lines_buf(lines_buf), .tags_buf(tags_buf),
        .hprots_buf(hprots_buf), .states_buf(states_buf),
        .upd_en(upd_en), .upd_way(upd_way), .upd_word_en(upd_word_en),
        .upd_line(upd_line), .upd_state(upd_state), .upd_tag_en(upd_tag_en),
        .upd_tag(upd_tag), .upd_hprot(upd_hprot), .upd_ready(upd_ready),
        .flush_req(flush_req), .lmem_wr_valid(lmem_wr_valid),
        .lmem_wr_ready(lmem_wr_ready), .lmem_wr_set(lmem_wr_set),
        .lmem_wr_way(lmem_wr_way), .lmem_wr_line(lmem_wr_line),
        .lmem_wr_tag(lmem_wr_tag), .lmem_wr_hprot(lmem_wr_hprot),
        .lmem_wr_state(lmem_wr_state), .flush_done(flush_done)
    );

    // Localmem source contents.
    logic [WAYS*WORDS*WORD_BITS-1:0]  src_lines;
    logic [WAYS*TAG_BITS-1:0]         src_tags;
    logic [WAYS*HPROT_BITS-1:0]       src_hprot;
    logic [WAYS*WORDS*STATE_BITS-1:0] src_states;

    // Localmem returns the set only in the cycle RD_LAT after the strobe,
    // and the bit-inverse otherwise, so a wrong sample point is visible.
    logic [2:0] rd_pipe = '0;
    always @(posedge clk) rd_pipe <= {rd_pipe[1:0], lmem_rd_en};
    assign rd_line  = rd_pipe[2] ? src_lines  : ~src_lines;
    assign rd_tag   = rd_pipe[2] ? src_tags   : ~src_tags;
    assign rd_hprot = rd_pipe[2] ? src_hprot  : ~src_hprot;
    assign rd_state = rd_pipe[2] ? src_states : ~src_states;
    assign rd_evict = rd_pipe[2] ? 3'd6 : 3'd1;

    int rd_en_cnt = 0;
    always @(negedge clk) if (lmem_rd_en) rd_en_cnt <= rd_en_cnt + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WAYS*WORDS*WORD_BITS-1:0]  exp_lines;
    logic [WAYS*TAG_BITS-1:0]         exp_tags;
    logic [WAYS*HPROT_BITS-1:0]       exp_hprot;
    logic [WAYS*WORDS*STATE_BITS-1:0] exp_states;

    task automatic chk_beat(input string tag, input int way);
        chk({tag, "_valid"}, lmem_wr_valid, 1'b1);
        chk({tag, "_way"},   lmem_wr_way, way);
        chk({tag, "_set"},   lmem_wr_set, 9'h1A3);
        chk({tag, "_line"},  lmem_wr_line, exp_lines[way*128 +: 128]);
        chk({tag, "_tag"},   lmem_wr_tag, exp_tags[way*16 +: 16]);
        chk({tag, "_hprot"}, lmem_wr_hprot, exp_hprot[way]);
        chk({tag, "_state"}, lmem_wr_state, exp_states[way*6 +: 6]);
    endtask

    task automatic do_upd(input int way, input logic [1:0] wen, input logic [127:0] line,
                          input logic [5:0] st, input logic ten, input logic [15:0] tg,
                          input logic hp);
        upd_en = 1'b1; upd_way = WB'(way); upd_word_en = wen; upd_line = line;
        upd_state = st; upd_tag_en = ten; upd_tag = tg; upd_hprot = hp;
        tick();
        upd_en = 1'b0; upd_word_en = '0; upd_tag_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < WAYS; i++) begin
            for (int w = 0; w < WORDS; w++) begin
                src_lines[(i*2+w)*64 +: 64] = {16'hC0DE, 8'(i), 8'(w), 32'h12345678 ^ 32'(i*16+w)};
                src_states[(i*2+w)*3 +: 3]  = 3'(i + w + 1);
            end
            src_tags[i*16 +: 16] = 16'h1000 + 16'(i);
            src_hprot[i]         = 1'(i);
        end

        // Reset state
        tick(); tick();
        chk("rst_buf_valid", buf_valid, 1'b0);
        chk("rst_dirty", dirty, 8'h00);
        chk("rst_lines", lines_buf, '0);
        chk("rst_wr_valid", lmem_wr_valid, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_upd_ready", upd_ready, 1'b0);
        rst = 1'b1;
        tick();
        chk("idle_load_ready", load_ready, 1'b1);

        // Flush in IDLE, with a competing load that must lose
        flush_req = 1'b1; load_req = 1'b1; load_set = 9'h055;
        #1 chk("idle_flush_rd_en", lmem_rd_en, 1'b0);
        tick();
        flush_req = 1'b0; load_req = 1'b0;
        chk("idle_flush_done", flush_done, 1'b1);
        chk("idle_flush_wr_valid", lmem_wr_valid, 1'b0);
        chk("idle_flush_buf_valid", buf_valid, 1'b0);
        tick();
        chk("idle_flush_done_pulse", flush_done, 1'b0);

        // Load set 0x1A3 with RD_LAT = 3
        load_req = 1'b1; load_set = 9'h1A3;
        #1;
        chk("load_rd_en", lmem_rd_en, 1'b1);
        chk("load_rd_set", lmem_rd_set, 9'h1A3);
        tick();                                      // T+1
        load_req = 1'b0;
        chk("wait_rd_en", lmem_rd_en, 1'b0);
        chk("wait_buf_set", buf_set, 9'h1A3);
        chk("wait_buf_valid", buf_valid, 1'b0);
        chk("wait_load_ready", load_ready, 1'b0);
        flush_req = 1'b1;
        tick();                                      // T+2, flush ignored in WAIT
        flush_req = 1'b0;
        chk("wait_flush_ignored", flush_done, 1'b0);
        tick();                                      // T+3
        chk("t3_buf_valid", buf_valid, 1'b0);
        tick();                                      // T+4
        chk("t4_buf_valid", buf_valid, 1'b1);
        chk("rd_en_one_cycle", rd_en_cnt, 1);
        chk("load_lines", lines_buf, src_lines);
        chk("load_tags", tags_buf, src_tags);
        chk("load_hprots", hprots_buf, src_hprot);
        chk("load_states", states_buf, src_states);
        chk("load_evict", evict_way_buf, 3'd6);
        chk("load_dirty", dirty, 8'h00);
        chk("hold_upd_ready", upd_ready, 1'b1);
        chk("hold_clean_load_ready", load_ready, 1'b1);
        exp_lines = src_lines; exp_tags = src_tags; exp_hprot = src_hprot; exp_states = src_states;

        // Update way 5, word 1 only
        do_upd(5, 2'b10, {64'hDEADBEEF00000005, 64'hBADBADBADBADBAD0}, {3'd3, 3'd7}, 1'b0, 16'h0, 1'b0);
        exp_lines[11*64 +: 64] = 64'hDEADBEEF00000005;
        exp_states[11*3 +: 3]  = 3'd3;
        chk("upd5_lines", lines_buf, exp_lines);
        chk("upd5_states", states_buf, exp_states);
        chk("upd5_dirty", dirty, 8'h20);
        chk("upd5_load_ready", load_ready, 1'b0);
        load_req = 1'b1; load_set = 9'h0F0;
        #1 chk("dirty_load_rd_en", lmem_rd_en, 1'b0);
        tick();
        load_req = 1'b0;
        chk("dirty_load_buf_set", buf_set, 9'h1A3);
        chk("dirty_load_buf_valid", buf_valid, 1'b1);

        // Update way 2 together with flush and load in the same cycle
        lmem_wr_ready = 1'b1;
        flush_req = 1'b1; load_req = 1'b1;
        #1 chk("flush_load_rd_en", lmem_rd_en, 1'b0);
        do_upd(2, 2'b01, {64'hFFFFFFFFFFFFFFFF, 64'h2222000000000002}, {3'd7, 3'd5}, 1'b0, 16'h0, 1'b0);
        flush_req = 1'b0; load_req = 1'b0;
        exp_lines[4*64 +: 64] = 64'h2222000000000002;
        exp_states[4*3 +: 3]  = 3'd5;
        chk("sim_dirty", dirty, 8'h24);
        chk_beat("sim_b0", 2);
        tick();
        chk_beat("sim_b1", 5);
        tick();
        chk("sim_done", flush_done, 1'b1);
        chk("sim_wr_valid_end", lmem_wr_valid, 1'b0);
        chk("sim_dirty_end", dirty, 8'h00);
        chk("sim_lines_kept", lines_buf, exp_lines);
        chk("sim_upd_ready", upd_ready, 1'b1);
        tick();
        chk("sim_done_pulse", flush_done, 1'b0);

        // Flush in HOLD with nothing dirty
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("clean_flush_done", flush_done, 1'b1);
        chk("clean_flush_wr_valid", lmem_wr_valid, 1'b0);

        // Dirty = 0x91, flush with first beat stalled two cycles
        lmem_wr_ready = 1'b0;
        do_upd(0, 2'b00, 128'h0, 6'h0, 1'b1, 16'hBEEF, 1'b1);
        do_upd(4, 2'b01, {64'h0, 64'h4444000000000004}, {3'd0, 3'd1}, 1'b0, 16'h0, 1'b0);
        do_upd(7, 2'b11, {64'h7171000000000007, 64'h7070000000000007}, {3'd6, 3'd2}, 1'b0, 16'h0, 1'b0);
        exp_tags[0 +: 16]      = 16'hBEEF;
        exp_hprot[0]           = 1'b1;
        exp_lines[8*64 +: 64]  = 64'h4444000000000004;
        exp_states[8*3 +: 3]   = 3'd1;
        exp_lines[14*64 +: 64] = 64'h7070000000000007;
        exp_lines[15*64 +: 64] = 64'h7171000000000007;
        exp_states[14*3 +: 3]  = 3'd2;
        exp_states[15*3 +: 3]  = 3'd6;
        chk("d91_dirty", dirty, 8'h91);
        chk("d91_tags", tags_buf, exp_tags);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk_beat("stall_c1", 0);
        tick();
        chk_beat("stall_c2", 0);
        tick();
        chk_beat("stall_c3", 0);
        lmem_wr_ready = 1'b1;
        tick();
        chk_beat("d91_b1", 4);
        chk("d91_dirty_mid", dirty, 8'h90);
        tick();
        chk_beat("d91_b2", 7);
        chk("d91_done_early", flush_done, 1'b0);
        tick();
        chk("d91_done", flush_done, 1'b1);
        chk("d91_dirty_end", dirty, 8'h00);
        chk("d91_wr_valid_end", lmem_wr_valid, 1'b0);

        // Reset in the middle of a three-beat flush
        do_upd(1, 2'b01, {64'h0, 64'h1111}, 6'h1, 1'b0, 16'h0, 1'b0);
        do_upd(3, 2'b01, {64'h0, 64'h3333}, 6'h1, 1'b0, 16'h0, 1'b0);
        do_upd(6, 2'b01, {64'h0, 64'h6666}, 6'h1, 1'b0, 16'h0, 1'b0);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("rf_b0_way", lmem_wr_way, 3'd1);
        tick();
        chk("rf_b1_way", lmem_wr_way, 3'd3);
        rst = 1'b0;
        #1;
        chk("rf_wr_valid", lmem_wr_valid, 1'b0);
        chk("rf_wr_line", lmem_wr_line, '0);
        chk("rf_buf_valid", buf_valid, 1'b0);
        chk("rf_dirty", dirty, 8'h00);
        chk("rf_lines", lines_buf, '0);
        chk("rf_buf_set", buf_set, 9'h0);
        chk("rf_upd_ready", upd_ready, 1'b0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rf_no_done", flush_done, 1'b0);
            chk("rf_no_wr_valid", lmem_wr_valid, 1'b0);
        end
        chk("rf_idle_load_ready", load_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
